// File: rtl/uart_mux_pkg.sv
// Shared framing definitions for the game-state link: word tags, snapshot
// layout and the word builder used on both ends of the link.
package uart_mux_pkg;

  localparam logic [3:0] TAG_MATCH_CTRL = 4'h0;
  localparam logic [3:0] TAG_PL1_POSX   = 4'h3;
  localparam logic [3:0] TAG_PL1_POSY   = 4'h4;
  localparam logic [3:0] TAG_BALL_POSX  = 4'h5;
  localparam logic [3:0] TAG_BALL_POSY  = 4'h6;

  localparam logic [2:0] IDX_LAST = 3'd4;

  typedef struct packed {
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] ball_posx;
    logic [11:0] ball_posy;
    logic [3:0]  pl1_score;
    logic [3:0]  pl2_score;
    logic        flag_point;
    logic        end_game;
    logic        reset_req;
  } game_snap_t;

  function automatic logic [15:0] frame_word(input logic [2:0] idx, input game_snap_t s);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {TAG_MATCH_CTRL, 1'b0, s.reset_req, s.end_game, s.flag_point,
                    s.pl2_score, s.pl1_score};
      3'd1:    w = {TAG_PL1_POSX, s.pl1_posx};
      3'd2:    w = {TAG_PL1_POSY, s.pl1_posy};
      3'd3:    w = {TAG_BALL_POSX, s.ball_posx};
      3'd4:    w = {TAG_BALL_POSY, s.ball_posy};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/uart_mux.sv
// Game-state framer: snapshots the state on frame_tick and streams five tagged
// words, high byte first, through the uart_tx start/done handshake.
module uart_mux
  import uart_mux_pkg::*;
#(
  parameter int unsigned WORD_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  input  logic        reset_req,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_HI = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_LOAD_LO = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;
  localparam logic [2:0] S_GAP     = 3'd5;

  localparam logic        GAP_EN   = (WORD_GAP != 0);
  localparam logic [15:0] GAP_LAST = GAP_EN ? 16'(WORD_GAP - 1) : 16'd0;

  logic [2:0]  state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic        pending_q, pending_d;
  game_snap_t  snap_q, snap_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;
  logic        busy_q, busy_d;

  game_snap_t  snap_in;
  logic [15:0] cur_word;
  logic        done_ok;

  assign snap_in = '{pl1_posx: pl1_posx, pl1_posy: pl1_posy,
                     ball_posx: ball_posx, ball_posy: ball_posy,
                     pl1_score: pl1_score, pl2_score: pl2_score,
                     flag_point: flag_point, end_game: end_game,
                     reset_req: reset_req};

  assign cur_word = frame_word(idx_q, snap_q);
  // A done pulse coinciding with our own start pulse belongs to no byte of ours.
  assign done_ok  = tx_done && !tx_start_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    if (frame_tick && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick || pending_q) begin
          snap_d    = snap_in;
          idx_d     = 3'd0;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = S_LOAD_HI;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_LOAD_HI: begin
        tx_data_d  = cur_word[15:8];
        tx_start_d = 1'b1;
        state_d    = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (done_ok) begin
          state_d = S_LOAD_LO;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_LOAD_LO: begin
        tx_data_d  = cur_word[7:0];
        tx_start_d = 1'b1;
        state_d    = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (done_ok) begin
          if (idx_q == IDX_LAST) begin
            // A queued request chains straight into a new frame without idling.
            if (pending_q || frame_tick) begin
              snap_d    = snap_in;
              idx_d     = 3'd0;
              pending_d = 1'b0;
              state_d   = S_LOAD_HI;
            end else begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else if (!GAP_EN) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_LOAD_HI;
          end else begin
            gap_cnt_d = 16'd0;
            state_d   = S_GAP;
          end
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_LOAD_HI;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: begin
        idx_d     = 3'd0;
        pending_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 3'd0;
      gap_cnt_q  <= 16'd0;
      pending_q  <= 1'b0;
      snap_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_cnt_q  <= gap_cnt_d;
      pending_q  <= pending_d;
      snap_q     <= snap_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_mux.sv
// Bench for uart_mux: two instances (no gap, WORD_GAP=4) share stimulus and are
// compared every cycle against a timing/byte-queue model of the link.
module tb_uart_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic [11:0] pl1_posx = 12'h0, pl1_posy = 12'h0, ball_posx = 12'h0, ball_posy = 12'h0;
  logic [3:0]  pl1_score = 4'h0, pl2_score = 4'h0;
  logic        flag_point = 1'b0, end_game = 1'b0, reset_req = 1'b0;
  logic [1:0]  tx_done = 2'b00;
  logic [1:0]  tx_start, busy;
  logic [1:0][7:0] tx_data;

  uart_mux #(.WORD_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point),
    .end_game(end_game), .reset_req(reset_req), .tx_done(tx_done[0]),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .busy(busy[0]));

  uart_mux #(.WORD_GAP(4)) dut1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point),
    .end_game(end_game), .reset_req(reset_req), .tx_done(tx_done[1]),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .busy(busy[1]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit spur_en = 1'b0;

  // model state per instance
  bit         m_active [2];
  bit         m_pending[2];
  bit         m_wait   [2];
  int         m_pos    [2];
  int         m_start_at[2];
  int         m_start_edge[2];
  logic [79:0] m_frame [2];
  logic       e_start  [2];
  logic       e_busy   [2];
  logic [7:0] e_data   [2];
  bit         done_ok_m;

  int due[2] = '{-1, -1};
  int last_done[2] = '{-1000, -1000};
  logic [7:0] log0[$];
  int d0[$];
  int d1[$];
  int s0[$];
  int tick_cyc = 0;
  int fall_cyc = 0;
  logic prev_busy0 = 1'b0;

  logic [7:0] exp1 [10] = '{8'h01, 8'h53, 8'h30, 8'h00, 8'h40, 8'h00, 8'h50, 8'h00, 8'h60, 8'h00};

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d] got %0h expected %0h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  // Frame contents straight from the word table: five tagged words, high byte first.
  function automatic logic [79:0] frame_now();
    logic [15:0] w0, w1, w2, w3, w4;
    w0 = {4'h0, 1'b0, reset_req, end_game, flag_point, pl2_score, pl1_score};
    w1 = {4'h3, pl1_posx};
    w2 = {4'h4, pl1_posy};
    w3 = {4'h5, ball_posx};
    w4 = {4'h6, ball_posy};
    return {w0, w1, w2, w3, w4};
  endfunction

  task automatic m_begin(input int i);
    m_frame[i]    = frame_now();
    m_pos[i]      = 0;
    m_active[i]   = 1'b1;
    e_busy[i]     = 1'b1;
    m_start_at[i] = cyc + 1;
  endtask

  // Reference model: advances at each edge; e_* are the outputs expected after it.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_active[i] = 1'b0; m_pending[i] = 1'b0; m_wait[i] = 1'b0; m_pos[i] = 0;
        m_start_at[i] = -1; m_start_edge[i] = -10;
        e_start[i] = 1'b0; e_busy[i] = 1'b0; e_data[i] = 8'h00;
      end else begin
        e_start[i] = 1'b0;
        done_ok_m = tx_done[i] && m_wait[i] && (m_start_edge[i] < cyc - 1);
        if (!m_active[i]) begin
          if (frame_tick) m_begin(i);
        end else if (done_ok_m) begin
          m_wait[i] = 1'b0;
          if (m_pos[i] == 10) begin
            if (m_pending[i] || frame_tick) begin
              m_pending[i] = 1'b0;
              m_begin(i);
            end else begin
              m_active[i] = 1'b0;
              e_busy[i]   = 1'b0;
            end
          end else begin
            m_start_at[i] = cyc + 1 + (((m_pos[i] % 2) == 0) ? gap_of(i) : 0);
            if (frame_tick) m_pending[i] = 1'b1;
          end
        end else if (frame_tick) begin
          m_pending[i] = 1'b1;
        end
        if (m_start_at[i] == cyc) begin
          e_start[i]      = 1'b1;
          e_data[i]       = m_frame[i][79 - 8*m_pos[i] -: 8];
          m_pos[i]        = m_pos[i] + 1;
          m_wait[i]       = 1'b1;
          m_start_edge[i] = cyc;
          m_start_at[i]   = -1;
        end
      end
    end
  end

  // uart_tx stand-in: done 10 cycles after each start, plus harmless spurious pulses.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      tx_done[i] = 1'b0;
      if (due[i] == cyc) begin
        tx_done[i]   = 1'b1;
        last_done[i] = cyc;
      end else if (spur_en && (e_start[i] || !m_active[i]) && ($urandom_range(0, 3) == 0)) begin
        tx_done[i] = 1'b1;
      end
    end
  end

  // Per-cycle compare and event logging.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (chk_en) begin
        chk("tx_start", i, tx_start[i], e_start[i]);
        chk("busy", i, busy[i], e_busy[i]);
        chk("tx_data", i, tx_data[i], e_data[i]);
      end
      if (rst) due[i] = -1;
      else if (tx_start[i]) due[i] = cyc + 10;
    end
    if (tx_start[0]) begin
      log0.push_back(tx_data[0]);
      d0.push_back(cyc - last_done[0]);
      s0.push_back(cyc);
    end
    if (tx_start[1]) d1.push_back(cyc - last_done[1]);
    if (prev_busy0 && !busy[0]) fall_cyc = cyc;
    prev_busy0 = busy[0];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick_cyc = cyc;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic randomize_inputs();
    pl1_posx = 12'($urandom); pl1_posy = 12'($urandom);
    ball_posx = 12'($urandom); ball_posy = 12'($urandom);
    pl1_score = 4'($urandom); pl2_score = 4'($urandom);
    flag_point = 1'($urandom); end_game = 1'($urandom); reset_req = 1'($urandom);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    step();
    while ((busy != 2'b00) && (n < limit)) begin
      step();
      n++;
    end
    chk("idle_timeout", 0, busy, 2'b00);
    repeat (3) step();
  endtask

  initial begin
    int n;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) step();
    chk("rst_tx_start", 0, tx_start[0], 1'b0);
    chk("rst_busy", 0, busy[0], 1'b0);
    chk("rst_tx_data", 0, tx_data[0], 8'h00);
    rst = 1'b0;
    step();

    // Frame 1: known MATCH_CTRL content, zero positions.
    pl1_score = 4'd3; pl2_score = 4'd5; flag_point = 1'b1;
    log0.delete(); d0.delete(); d1.delete(); s0.delete();
    pulse_tick();
    wait_idle(600);
    chk("t1_len", 0, log0.size(), 10);
    for (int j = 0; j < 10; j++) chk("t1_byte", j, log0[j], exp1[j]);
    chk("t1_first_latency", 0, s0[0] - tick_cyc, 2);
    chk("t1_byte_spacing", 0, s0[1] - s0[0], 12);
    chk("t1_busy_fall", 0, fall_cyc - last_done[0], 1);
    chk("t1_gap_in_word", 1, d1[1], 2);
    chk("t1_gap_word", 1, d1[2], 6);

    // Frame 2: snapshot must survive input changes right after the tick.
    spur_en = 1'b1;
    pl1_posx = 12'hABC; ball_posy = 12'h123;
    log0.delete();
    pulse_tick();
    randomize_inputs();
    wait_idle(600);
    chk("t2_px_hi", 0, log0[2], 8'h3A);
    chk("t2_px_lo", 0, log0[3], 8'hBC);
    chk("t2_by_hi", 0, log0[8], 8'h61);
    chk("t2_by_lo", 0, log0[9], 8'h23);

    // Two ticks mid-frame: exactly one chained frame follows.
    log0.delete(); d0.delete();
    pulse_tick();
    repeat (20) step();
    randomize_inputs();
    pulse_tick();
    repeat (30) step();
    pulse_tick();
    wait_idle(1200);
    chk("t3_len", 0, log0.size(), 20);
    chk("t3_chain_latency", 0, d0[10], 2);

    // Reset while waiting on word 2's low byte.
    log0.delete();
    pulse_tick();
    n = 0;
    while (!(m_wait[0] && (m_pos[0] == 6) && (m_start_edge[0] < cyc - 1)) && (n < 500)) begin
      step();
      n++;
    end
    chk("t4_reach_wait_lo", 0, m_pos[0], 6);
    step();
    rst = 1'b1;
    step();
    chk("t4_rst_tx_start", 0, tx_start[0], 1'b0);
    chk("t4_rst_busy", 0, busy[0], 1'b0);
    chk("t4_rst_tx_data", 0, tx_data[0], 8'h00);
    chk("t4_rst_busy1", 1, busy[1], 1'b0);
    rst = 1'b0;
    step();
    reset_req = 1'b1; end_game = 1'b0; flag_point = 1'b1; pl2_score = 4'd9; pl1_score = 4'd2;
    log0.delete();
    pulse_tick();
    wait_idle(600);
    chk("t4_len", 0, log0.size(), 10);
    chk("t4_ctrl_hi", 0, log0[0], 8'h05);
    chk("t4_ctrl_lo", 0, log0[1], 8'h92);

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 7) == 0) randomize_inputs();
      frame_tick = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 1999) == 0);
      step();
    end
    frame_tick = 1'b0;
    rst = 1'b0;
    wait_idle(2000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
